// File: rtl/sb_dcache_store_port_pkg.sv
// Shared encodings for the store-buffer drain port: memory access types, entry pointer width
// and the store-port FSM state set.
package sb_dcache_store_port_pkg;

    localparam int unsigned SB_PTR_W = 3;

    localparam logic [1:0] MAT_UNCACHED = 2'b00;
    localparam logic [1:0] MAT_CACHED   = 2'b01;

    typedef enum logic [2:0] {
        StIdle,
        StCreq,
        StCwait,
        StRefill,
        StUreq,
        StUwait,
        StDone
    } sp_state_e;

    // Only the 2'b01 encoding goes through the cache; every other MAT is treated as uncached.
    function automatic logic is_cached(input logic [1:0] mat);
        return mat == MAT_CACHED;
    endfunction

endpackage

// File: rtl/sb_dcache_store_port.sv
// Store-buffer drain port: takes one retired store at a time, writes it to the D-cache (with
// miss refill and bounded retry) or to the uncached bus, and reports accept/complete pulses.
module sb_dcache_store_port
    import sb_dcache_store_port_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned LINE_OFF_W = 4,
    parameter int unsigned RETRY_MAX  = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,

    input  logic                sb_to_dcd_able,
    input  logic [1:0]          sb_to_dcd_a_mat,
    input  logic [SB_PTR_W-1:0] sb_to_dcd_a_ptr,
    input  logic [ADDR_W-1:0]   sb_to_dcd_a_phy_addr,
    input  logic [DATA_W-1:0]   sb_to_dcd_a_phy_data,
    input  logic [3:0]          sb_to_dcd_a_strb,

    output logic                dcd_to_sb_success,
    output logic                dcd_to_sb_back_able,
    output logic [SB_PTR_W-1:0] dcd_to_sb_back_ptr,
    output logic                dcd_to_sb_err,

    output logic                cache_req,
    output logic [ADDR_W-1:0]   cache_addr,
    output logic [DATA_W-1:0]   cache_data,
    output logic [3:0]          cache_strb,
    input  logic                cache_ready,
    input  logic                cache_resp_valid,
    input  logic                cache_hit,

    output logic                refill_req,
    output logic [ADDR_W-1:0]   refill_addr,
    input  logic                refill_done,

    output logic                unc_req,
    output logic [ADDR_W-1:0]   unc_addr,
    output logic [DATA_W-1:0]   unc_data,
    output logic [3:0]          unc_strb,
    input  logic                unc_ready,
    input  logic                unc_b_valid,

    output logic                port_idle
);

    // Counter must be able to hold RETRY_MAX + 1 so the over-limit miss is representable.
    localparam int unsigned CNT_W = $clog2(RETRY_MAX + 2);
    localparam logic [CNT_W-1:0] RETRY_LIM = CNT_W'(RETRY_MAX);

    sp_state_e state_q, state_d;

    logic [SB_PTR_W-1:0] ptr_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic [3:0]          strb_q;

    logic [CNT_W-1:0] retry_cnt_q, retry_cnt_d, retry_inc;
    logic             squash_q, squash_d;
    logic             err_q, err_d;

    logic                cache_req_q, refill_req_q, unc_req_q, port_idle_q;
    logic                back_able_q, back_err_q;
    logic [SB_PTR_W-1:0] back_ptr_q;

    logic accept;

    assign accept    = (state_q == StIdle) & sb_to_dcd_able & ~flush &
                       (sb_to_dcd_a_ptr != '0);
    assign retry_inc = retry_cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        retry_cnt_d = retry_cnt_q;
        squash_d    = squash_q;
        err_d       = err_q;

        // A flush while busy cannot abort the bus transaction; it only suppresses completion.
        if (state_q != StIdle && flush) begin
            squash_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d     = is_cached(sb_to_dcd_a_mat) ? StCreq : StUreq;
                    retry_cnt_d = '0;
                    squash_d    = 1'b0;
                    err_d       = 1'b0;
                end
            end
            StCreq: begin
                if (cache_ready) begin
                    state_d = StCwait;
                end
            end
            StCwait: begin
                if (cache_resp_valid) begin
                    if (cache_hit) begin
                        state_d = StDone;
                    end else begin
                        retry_cnt_d = retry_inc;
                        if (retry_inc > RETRY_LIM) begin
                            err_d   = 1'b1;
                            state_d = StDone;
                        end else begin
                            state_d = StRefill;
                        end
                    end
                end
            end
            StRefill: begin
                if (refill_done) begin
                    state_d = StCreq;
                end
            end
            StUreq: begin
                if (unc_ready) begin
                    state_d = StUwait;
                end
            end
            StUwait: begin
                if (unc_b_valid) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            ptr_q        <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            strb_q       <= '0;
            retry_cnt_q  <= '0;
            squash_q     <= 1'b0;
            err_q        <= 1'b0;
            cache_req_q  <= 1'b0;
            refill_req_q <= 1'b0;
            unc_req_q    <= 1'b0;
            port_idle_q  <= 1'b1;
            back_able_q  <= 1'b0;
            back_err_q   <= 1'b0;
            back_ptr_q   <= '0;
        end else begin
            state_q     <= state_d;
            retry_cnt_q <= retry_cnt_d;
            squash_q    <= squash_d;
            err_q       <= err_d;

            if (accept) begin
                ptr_q  <= sb_to_dcd_a_ptr;
                addr_q <= sb_to_dcd_a_phy_addr;
                data_q <= sb_to_dcd_a_phy_data;
                strb_q <= sb_to_dcd_a_strb;
            end

            // Outputs are decoded from the next state so they line up with state_q.
            cache_req_q  <= (state_d == StCreq);
            refill_req_q <= (state_d == StRefill);
            unc_req_q    <= (state_d == StUreq);
            port_idle_q  <= (state_d == StIdle);
            back_able_q  <= (state_d == StDone) & ~squash_d;
            back_err_q   <= (state_d == StDone) & err_d & ~squash_d;
            back_ptr_q   <= (state_d == StDone) ? ptr_q : '0;
        end
    end

    assign dcd_to_sb_success   = accept;
    assign dcd_to_sb_back_able = back_able_q;
    assign dcd_to_sb_back_ptr  = back_ptr_q;
    assign dcd_to_sb_err       = back_err_q;

    // Payload comes straight from the capture registers, which only change on accept in idle,
    // so it is stable for the whole request window.
    assign cache_req   = cache_req_q;
    assign cache_addr  = addr_q;
    assign cache_data  = data_q;
    assign cache_strb  = strb_q;

    assign refill_req  = refill_req_q;
    assign refill_addr = {addr_q[ADDR_W-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};

    assign unc_req     = unc_req_q;
    assign unc_addr    = addr_q;
    assign unc_data    = data_q;
    assign unc_strb    = strb_q;

    assign port_idle   = port_idle_q;

endmodule

// File: tb/tb_sb_dcache_store_port.sv
// Self-checking bench for sb_dcache_store_port: scripted cache/uncached responders and a
// completion scoreboard fed at stimulus time and drained by a completion monitor.
module tb_sb_dcache_store_port;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned LINE_OFF_W = 4;
    localparam int unsigned RETRY_MAX  = 3;
    localparam logic [ADDR_W-1:0] LINE_MASK = 32'hFFFF_FFF0;

    typedef struct {
        logic [2:0] ptr;
        logic       err;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              able;
    logic [1:0]        mat;
    logic [2:0]        ptr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [3:0]        strb;
    logic              success;
    logic              back_able;
    logic [2:0]        back_ptr;
    logic              back_err;
    logic              cache_req;
    logic [ADDR_W-1:0] cache_addr;
    logic [DATA_W-1:0] cache_data;
    logic [3:0]        cache_strb;
    logic              cache_ready;
    logic              cache_resp_valid;
    logic              cache_hit;
    logic              refill_req;
    logic [ADDR_W-1:0] refill_addr;
    logic              refill_done;
    logic              unc_req;
    logic [ADDR_W-1:0] unc_addr;
    logic [DATA_W-1:0] unc_data;
    logic [3:0]        unc_strb;
    logic              unc_ready;
    logic              unc_b_valid;
    logic              port_idle;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    sb_dcache_store_port #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .LINE_OFF_W (LINE_OFF_W),
        .RETRY_MAX  (RETRY_MAX)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .flush                (flush),
        .sb_to_dcd_able       (able),
        .sb_to_dcd_a_mat      (mat),
        .sb_to_dcd_a_ptr      (ptr),
        .sb_to_dcd_a_phy_addr (addr),
        .sb_to_dcd_a_phy_data (data),
        .sb_to_dcd_a_strb     (strb),
        .dcd_to_sb_success    (success),
        .dcd_to_sb_back_able  (back_able),
        .dcd_to_sb_back_ptr   (back_ptr),
        .dcd_to_sb_err        (back_err),
        .cache_req            (cache_req),
        .cache_addr           (cache_addr),
        .cache_data           (cache_data),
        .cache_strb           (cache_strb),
        .cache_ready          (cache_ready),
        .cache_resp_valid     (cache_resp_valid),
        .cache_hit            (cache_hit),
        .refill_req           (refill_req),
        .refill_addr          (refill_addr),
        .refill_done          (refill_done),
        .unc_req              (unc_req),
        .unc_addr             (unc_addr),
        .unc_data             (unc_data),
        .unc_strb             (unc_strb),
        .unc_ready            (unc_ready),
        .unc_b_valid          (unc_b_valid),
        .port_idle            (port_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Completion monitor: every back_able pulse must match the oldest expected completion.
    always @(negedge clk) begin
        if (rst_n && back_able) begin
            if (exp_q.size() == 0) begin
                check("back_unexpected", 64'(back_able), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("back_ptr", 64'(back_ptr), 64'(mon_e.ptr));
                check("back_err", 64'(back_err), 64'(mon_e.err));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic accept(input logic [1:0] m, input logic [2:0] p, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input logic [3:0] s);
        step();
        able = 1'b1;
        mat  = m;
        ptr  = p;
        addr = a;
        data = d;
        strb = s;
        sample();
        check("success", 64'(success), 64'd1);
        step();
        able = 1'b0;
    endtask

    // Starts in the CREQ cycle; answers n_miss misses before a hit, ends in the DONE cycle.
    task automatic cached_body(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                               input int n_miss);
        int  misses;
        logic hit_now;
        misses = 0;
        for (int i = 0; i <= int'(RETRY_MAX) + 1; i++) begin
            cache_ready = 1'b1;
            sample();
            check("cache_req", 64'(cache_req), 64'd1);
            check("cache_addr", 64'(cache_addr), 64'(a));
            check("cache_data", 64'(cache_data), 64'(d));
            check("refill_in_creq", 64'(refill_req), 64'd0);
            step();
            cache_ready = 1'b0;
            sample();
            check("cache_req_cwait", 64'(cache_req), 64'd0);
            hit_now          = (misses >= n_miss);
            cache_resp_valid = 1'b1;
            cache_hit        = hit_now;
            step();
            cache_resp_valid = 1'b0;
            cache_hit        = 1'b0;
            if (hit_now) break;
            misses++;
            if (misses > int'(RETRY_MAX)) break;
            sample();
            check("refill_req", 64'(refill_req), 64'd1);
            check("refill_addr", 64'(refill_addr), 64'(a & LINE_MASK));
            refill_done = 1'b1;
            step();
            refill_done = 1'b0;
        end
    endtask

    // Starts in the UREQ cycle; ends in the DONE cycle.
    task automatic unc_body(input logic [ADDR_W-1:0] a, input int n_wait, input logic fl);
        for (int i = 0; i < n_wait; i++) begin
            sample();
            check("unc_req_hold", 64'(unc_req), 64'd1);
            check("unc_addr", 64'(unc_addr), 64'(a));
            check("no_cache_req", 64'(cache_req), 64'd0);
            step();
        end
        unc_ready = 1'b1;
        sample();
        check("unc_req", 64'(unc_req), 64'd1);
        step();
        unc_ready = 1'b0;
        sample();
        check("unc_req_uwait", 64'(unc_req), 64'd0);
        check("no_cache_req", 64'(cache_req), 64'd0);
        flush       = fl;
        unc_b_valid = 1'b1;
        step();
        unc_b_valid = 1'b0;
        flush       = 1'b0;
    endtask

    task automatic finish_done(input logic exp_back);
        sample();
        check("done_back_able", 64'(back_able), 64'(exp_back));
        check("done_refill_req", 64'(refill_req), 64'd0);
        check("done_cache_req", 64'(cache_req), 64'd0);
        check("done_unc_req", 64'(unc_req), 64'd0);
        check("done_not_idle", 64'(port_idle), 64'd0);
        step();
        sample();
        check("idle_after_done", 64'(port_idle), 64'd1);
    endtask

    initial begin
        rst_n = 1'b0;  flush = 1'b0;  able = 1'b0;  mat = 2'b00;  ptr = 3'd0;
        addr = '0;  data = '0;  strb = 4'h0;
        cache_ready = 1'b0;  cache_resp_valid = 1'b0;  cache_hit = 1'b0;
        refill_done = 1'b0;  unc_ready = 1'b0;  unc_b_valid = 1'b0;

        repeat (2) @(posedge clk);
        sample();
        check("rst_port_idle", 64'(port_idle), 64'd1);
        check("rst_back_able", 64'(back_able), 64'd0);
        check("rst_cache_req", 64'(cache_req), 64'd0);
        check("rst_unc_req", 64'(unc_req), 64'd0);
        check("rst_cache_addr", 64'(cache_addr), 64'd0);
        step();
        rst_n = 1'b1;

        // Cached hit with 1-cycle CREQ.
        exp_q.push_back('{ptr: 3'd3, err: 1'b0});
        accept(2'b01, 3'd3, 32'h1000_0004, 32'hDEAD_BEEF, 4'hF);
        cached_body(32'h1000_0004, 32'hDEAD_BEEF, 0);
        finish_done(1'b1);

        // Single miss, refill, retry hit.
        exp_q.push_back('{ptr: 3'd2, err: 1'b0});
        accept(2'b01, 3'd2, 32'h1000_0004, 32'h1234_5678, 4'h3);
        cached_body(32'h1000_0004, 32'h1234_5678, 1);
        finish_done(1'b1);

        // Persistent miss: RETRY_MAX+1 misses end in an error completion.
        exp_q.push_back('{ptr: 3'd1, err: 1'b1});
        accept(2'b01, 3'd1, 32'h2000_00AC, 32'hCAFE_F00D, 4'hF);
        cached_body(32'h2000_00AC, 32'hCAFE_F00D, int'(RETRY_MAX) + 1);
        finish_done(1'b1);

        // Uncached with backpressure; a new request held through DONE is refused there.
        exp_q.push_back('{ptr: 3'd7, err: 1'b0});
        accept(2'b00, 3'd7, 32'h3000_0010, 32'h0BAD_F00D, 4'hF);
        unc_body(32'h3000_0010, 2, 1'b0);
        able = 1'b1;  mat = 2'b01;  ptr = 3'd4;  addr = 32'h4000_0020;  data = 32'h5555_AAAA;
        sample();
        check("no_accept_in_done", 64'(success), 64'd0);
        check("done_back_able", 64'(back_able), 64'd1);
        step();
        sample();
        check("accept_after_done", 64'(success), 64'd1);
        exp_q.push_back('{ptr: 3'd4, err: 1'b0});
        step();
        able = 1'b0;
        cached_body(32'h4000_0020, 32'h5555_AAAA, 0);
        finish_done(1'b1);

        // Flush during UWAIT: response still consumed, completion suppressed.
        accept(2'b10, 3'd6, 32'h5000_0000, 32'h1111_2222, 4'hF);
        unc_body(32'h5000_0000, 0, 1'b1);
        finish_done(1'b0);

        // Ignored requests: ptr 0, flush in idle, stray responses.
        step();
        able = 1'b1;  mat = 2'b01;  ptr = 3'd0;
        sample();
        check("ptr0_no_success", 64'(success), 64'd0);
        ptr = 3'd5;  flush = 1'b1;
        sample();
        check("flush_idle_no_success", 64'(success), 64'd0);
        able = 1'b0;  flush = 1'b0;
        cache_resp_valid = 1'b1;  cache_hit = 1'b1;  refill_done = 1'b1;  unc_b_valid = 1'b1;
        step();
        cache_resp_valid = 1'b0;  cache_hit = 1'b0;  refill_done = 1'b0;  unc_b_valid = 1'b0;
        sample();
        check("stray_stays_idle", 64'(port_idle), 64'd1);

        // Async reset while in REFILL, with a fresh request waiting at release.
        accept(2'b01, 3'd6, 32'h6000_0048, 32'h7777_8888, 4'hF);
        cache_ready = 1'b1;
        step();
        cache_ready = 1'b0;
        cache_resp_valid = 1'b1;  cache_hit = 1'b0;
        step();
        cache_resp_valid = 1'b0;
        sample();
        check("refill_before_rst", 64'(refill_req), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_drops_refill", 64'(refill_req), 64'd0);
        check("rst_idle_async", 64'(port_idle), 64'd1);
        able = 1'b1;  mat = 2'b01;  ptr = 3'd5;  addr = 32'h7000_0008;  data = 32'h9999_0000;
        step();
        rst_n = 1'b1;
        sample();
        check("accept_after_rst", 64'(success), 64'd1);
        exp_q.push_back('{ptr: 3'd5, err: 1'b0});
        step();
        able = 1'b0;
        cached_body(32'h7000_0008, 32'h9999_0000, 0);
        finish_done(1'b1);

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
